// File: rtl/mips_lsu_pkg.sv
// Shared types and helpers for the MIPS multi-cycle load/store sequencer.
// Sizes, FSM states, default response timeout and address-alignment helpers.
package mips_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } lsu_size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_t;

  localparam int unsigned LSU_TIMEOUT_DEFAULT = 16;

  // The encoding 2'b11 has no instruction of its own and behaves as a word.
  function automatic lsu_size_t decode_size(input logic [1:0] raw);
    case (raw)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input lsu_size_t sz, input logic [1:0] lo);
    case (sz)
      SZ_HALF: return lo[0];
      SZ_WORD: return |lo;
      default: return 1'b0;
    endcase
  endfunction

  // Clears the low address bits a misaligned access would violate.
  function automatic logic [1:0] align_lo(input lsu_size_t sz, input logic [1:0] lo);
    case (sz)
      SZ_HALF: return {lo[1], 1'b0};
      SZ_WORD: return 2'b00;
      default: return lo;
    endcase
  endfunction

endpackage

// File: rtl/mips_lsu_ctrl_if.sv
// Word-addressed data-memory port between the load/store sequencer and memory.
// The sequencer is the master; the memory (or its model) is the slave.
interface mips_lsu_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mips_lsu_align.sv
// Combinational lane logic: byte enables, store-data replication and
// load lane selection with sign/zero extension.
module mips_lsu_align
  import mips_lsu_pkg::*;
(
  input  lsu_size_t   sz,
  input  logic [1:0]  lo,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_ext
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    // NOTE: every output gets a value before the case so no path infers a latch.
    byte_lane = rdata[{lo, 3'b000} +: 8];
    half_lane = lo[1] ? rdata[31:16] : rdata[15:0];
    be        = 4'b1111;
    wdata_rep = wdata;
    load_ext  = rdata;
    case (sz)
      SZ_BYTE: begin
        be        = 4'b0001 << lo;
        wdata_rep = {4{wdata[7:0]}};
        load_ext  = {{24{sign_ext & byte_lane[7]}}, byte_lane};
      end
      SZ_HALF: begin
        be        = lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        load_ext  = {{16{sign_ext & half_lane[15]}}, half_lane};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_lsu_ctrl.sv
// Multi-cycle load/store sequencer: stalls the core while one access runs on
// the memory port. Define MIPS_LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module mips_lsu_ctrl
  import mips_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT,
  parameter int unsigned TO_W           = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic        op_write,
  input  logic [1:0]  op_size,
  input  logic        op_signed,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        addr_err,
  output logic        bus_err,
  mips_lsu_ctrl_if.master mem
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  lsu_state_t state_q, state_d;
  lsu_size_t  op_sz, size_q, al_size;
  logic [1:0] op_lo, lo_q, al_lo;
  logic       sign_q, al_sign, we_q, trap, req;
  logic [29:0] addr_q;
  logic [3:0]  be_q, al_be;
  logic [31:0] wdata_q, load_q, al_wdata, al_load;
  logic        aerr_q, berr_q;
  logic [TO_W-1:0] to_cnt_q, to_cnt_inc;
  logic            to_hit;

  assign op_sz = decode_size(op_size);
  assign op_lo = align_lo(op_sz, op_addr[1:0]);

`ifdef MIPS_LSU_MISALIGN_TRAP_EN
  assign trap = is_misaligned(op_sz, op_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign to_cnt_inc = to_cnt_q + TO_W'(1);
  assign to_hit     = (to_cnt_inc == TO_LIMIT);

  // One aligner serves both paths: the incoming op while idle, the latched op while busy.
  assign al_size = (state_q == ST_IDLE) ? op_sz     : size_q;
  assign al_lo   = (state_q == ST_IDLE) ? op_lo     : lo_q;
  assign al_sign = (state_q == ST_IDLE) ? op_signed : sign_q;

  mips_lsu_align u_align (
    .sz        (al_size),
    .lo        (al_lo),
    .sign_ext  (al_sign),
    .wdata     (op_wdata),
    .rdata     (mem.mem_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .load_ext  (al_load)
  );

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    done    = 1'b0;
    req     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall = op_valid & ~rst;
        if (op_valid) state_d = trap ? ST_DONE : ST_BUSY;
      end
      ST_BUSY: begin
        stall = 1'b1;
        req   = 1'b1;
        // An ack in the same cycle as the timeout still counts as success.
        if (mem.mem_ack || to_hit) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_q   <= SZ_BYTE;
      lo_q     <= 2'b00;
      sign_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      load_q   <= '0;
      aerr_q   <= 1'b0;
      berr_q   <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (op_valid) begin
            aerr_q <= 1'b0;
            berr_q <= 1'b0;
            if (trap) begin
              aerr_q <= 1'b1;
              if (!op_write) load_q <= '0;
            end else begin
              size_q   <= op_sz;
              lo_q     <= op_lo;
              sign_q   <= op_signed;
              we_q     <= op_write;
              addr_q   <= op_addr[31:2];
              be_q     <= al_be;
              wdata_q  <= al_wdata;
              to_cnt_q <= '0;
            end
          end
        end
        ST_BUSY: begin
          if (mem.mem_ack) begin
            if (!we_q) load_q <= al_load;
          end else begin
            to_cnt_q <= to_cnt_inc;
            if (to_hit) begin
              berr_q <= 1'b1;
              if (!we_q) load_q <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Request is decoded from state so an asynchronous reset drops it at once.
  assign mem.mem_req   = req;
  assign mem.mem_we    = req & we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;

  assign load_data = load_q;
  assign addr_err  = aerr_q;
  assign bus_err   = berr_q;

endmodule

// File: tb/tb_mips_lsu_ctrl.sv
// Self-checking bench for mips_lsu_ctrl: directed vector table, multi-cycle
// corner sequences and random ops against a behavioural memory-access model.
module tb_mips_lsu_ctrl;

  localparam int TMO = 16;
`ifdef MIPS_LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_at;   // busy cycle carrying the ack, 0 = never
  } op_t;

  typedef struct {
    logic [3:0]  be;
    logic [29:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] ld;
    logic        aerr;
    logic        berr;
    int          req_cnt;
  } exp_t;

  typedef struct {
    op_t  op;
    exp_t e;
  } vec_t;

  typedef struct {
    int          stall_cnt;
    int          req_cnt;
    logic        got_done;
    logic        we;
    logic [3:0]  be;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [31:0] ld;
    logic        aerr;
    logic        berr;
    logic        stable;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0, op_write = 1'b0, op_signed = 1'b0;
  logic [1:0]  op_size = 2'b00;
  logic [31:0] op_addr = '0, op_wdata = '0;
  logic        stall, done, addr_err, bus_err;
  logic [31:0] load_data;

  int n_checks = 0;
  int n_fail   = 0;

  mips_lsu_ctrl_if mem ();

  mips_lsu_ctrl #(.TIMEOUT_CYCLES(TMO), .TO_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op_write  (op_write),
    .op_size   (op_size),
    .op_signed (op_signed),
    .op_addr   (op_addr),
    .op_wdata  (op_wdata),
    .stall     (stall),
    .done      (done),
    .load_data (load_data),
    .addr_err  (addr_err),
    .bus_err   (bus_err),
    .mem       (mem)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Behavioural view of one access: byte count, lane, arithmetic masks.
  function automatic exp_t model(input op_t o, input logic [31:0] prev);
    exp_t e;
    int unsigned nb, lane, ea;
    logic [31:0] mask, v;
    nb = (o.sz == 2'd0) ? 1 : (o.sz == 2'd1) ? 2 : 4;
    e = '{default: 0};
    e.we = o.wr;
    e.ld = prev;
    if (TRAP && (o.addr % nb) != 0) begin
      e.aerr = 1'b1;
      if (!o.wr) e.ld = '0;
      return e;
    end
    ea     = o.addr - (o.addr % nb);
    lane   = ea % 4;
    e.be   = 4'(((1 << nb) - 1) << lane);
    e.addr = 30'(ea / 4);
    case (nb)
      1:       e.wdata = (o.wdata & 32'hFF) * 32'h0101_0101;
      2:       e.wdata = (o.wdata & 32'hFFFF) * 32'h0001_0001;
      default: e.wdata = o.wdata;
    endcase
    if (o.ack_at == 0 || o.ack_at > TMO) begin
      e.berr    = 1'b1;
      e.req_cnt = TMO;
      if (!o.wr) e.ld = '0;
    end else begin
      e.req_cnt = o.ack_at;
      if (!o.wr) begin
        mask = (nb == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * nb)) - 1);
        v    = (o.rdata >> (8 * lane)) & mask;
        if (o.sg && nb < 4 && v[8*nb-1]) v = v | ~mask;
        e.ld = v;
      end
    end
    return e;
  endfunction

  // Starts right after a falling edge; returns at the falling edge after done.
  task automatic run_op(input op_t o, input bit noise, output res_t r);
    bit first;
    int busy;
    r = '{default: 0};
    r.stable = 1'b1;
    first = 1'b1;
    busy = 0;
    op_valid = 1'b1; op_write = o.wr; op_size = o.sz; op_signed = o.sg;
    op_addr = o.addr; op_wdata = o.wdata;
    for (int cyc = 0; cyc < 64; cyc++) begin
      #1;
      if (mem.mem_req) begin
        busy++;
        r.req_cnt++;
        if (first) begin
          r.be = mem.mem_be; r.addr = mem.mem_addr; r.wdata = mem.mem_wdata; r.we = mem.mem_we;
        end else if (r.be !== mem.mem_be || r.addr !== mem.mem_addr ||
                     r.wdata !== mem.mem_wdata || r.we !== mem.mem_we) begin
          r.stable = 1'b0;
        end
        first = 1'b0;
        mem.mem_ack   = (busy == o.ack_at);
        mem.mem_rdata = (busy == o.ack_at) ? o.rdata : $urandom;
      end else begin
        mem.mem_ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        mem.mem_rdata = $urandom;
      end
      if (stall) r.stall_cnt++;
      if (done) begin
        r.got_done = 1'b1;
        r.ld = load_data; r.aerr = addr_err; r.berr = bus_err;
      end
      @(negedge clk);
      if (r.got_done) break;
    end
    op_valid = 1'b0;
    mem.mem_ack = 1'b0;
  endtask

  task automatic compare(input string tag, input res_t r, input exp_t e);
    check({tag, ".done"}, 32'(r.got_done), 32'd1);
    if (e.req_cnt > 0) begin
      check({tag, ".be"}, 32'(r.be), 32'(e.be));
      check({tag, ".mem_addr"}, 32'(r.addr), 32'(e.addr));
      check({tag, ".we"}, 32'(r.we), 32'(e.we));
      if (e.we) check({tag, ".wdata"}, r.wdata, e.wdata);
    end
    check({tag, ".load_data"}, r.ld, e.ld);
    check({tag, ".addr_err"}, 32'(r.aerr), 32'(e.aerr));
    check({tag, ".bus_err"}, 32'(r.berr), 32'(e.berr));
    check({tag, ".req_cycles"}, 32'(r.req_cnt), 32'(e.req_cnt));
    check({tag, ".stall_cycles"}, 32'(r.stall_cnt), 32'(e.req_cnt + 1));
    check({tag, ".stable"}, 32'(r.stable), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[12];
    res_t r;
    exp_t e;
    op_t  o;
    logic [31:0] prev;
    int   bad;

    vecs[0]  = '{'{1'b0, 2'b10, 1'b0, 32'h1004, 32'h0, 32'hDEADBEEF, 3},
                 '{4'hF, 30'h401, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 3}};
    vecs[1]  = '{'{1'b0, 2'b00, 1'b1, 32'h2003, 32'h0, 32'h80112233, 1},
                 '{4'h8, 30'h800, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0, 1}};
    vecs[2]  = '{'{1'b0, 2'b00, 1'b0, 32'h2003, 32'h0, 32'h80112233, 2},
                 '{4'h8, 30'h800, 1'b0, 32'h0, 32'h00000080, 1'b0, 1'b0, 2}};
    vecs[3]  = '{'{1'b1, 2'b01, 1'b0, 32'h3002, 32'h0000ABCD, 32'h0, 2},
                 '{4'hC, 30'hC00, 1'b1, 32'hABCDABCD, 32'h00000080, 1'b0, 1'b0, 2}};
    vecs[4]  = '{'{1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h12348765, 1},
                 '{4'h3, 30'h4, 1'b0, 32'h0, 32'hFFFF8765, 1'b0, 1'b0, 1}};
    vecs[5]  = '{'{1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h87651234, 4},
                 '{4'hC, 30'h4, 1'b0, 32'h0, 32'h00008765, 1'b0, 1'b0, 4}};
    vecs[6]  = '{'{1'b1, 2'b00, 1'b0, 32'h5, 32'h123456A5, 32'h0, 1},
                 '{4'h2, 30'h1, 1'b1, 32'hA5A5A5A5, 32'h00008765, 1'b0, 1'b0, 1}};
    vecs[7]  = '{'{1'b1, 2'b10, 1'b0, 32'h8, 32'hCAFEF00D, 32'h0, 3},
                 '{4'hF, 30'h2, 1'b1, 32'hCAFEF00D, 32'h00008765, 1'b0, 1'b0, 3}};
    vecs[8]  = '{'{1'b0, 2'b11, 1'b1, 32'h20, 32'h0, 32'h89ABCDEF, 1},
                 '{4'hF, 30'h8, 1'b0, 32'h0, 32'h89ABCDEF, 1'b0, 1'b0, 1}};
    vecs[9]  = '{'{1'b0, 2'b00, 1'b0, 32'h41, 32'h0, 32'h00009900, 2},
                 '{4'h2, 30'h10, 1'b0, 32'h0, 32'h00000099, 1'b0, 1'b0, 2}};
    vecs[10] = '{'{1'b1, 2'b00, 1'b0, 32'h7, 32'h000000FF, 32'h0, 1},
                 '{4'h8, 30'h1, 1'b1, 32'hFFFFFFFF, 32'h00000099, 1'b0, 1'b0, 1}};
    vecs[11] = '{'{1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 32'h7FFF0000, 2},
                 '{4'hC, 30'h5, 1'b0, 32'h0, 32'h00007FFF, 1'b0, 1'b0, 2}};

    mem.mem_ack = 1'b0;
    mem.mem_rdata = '0;

    // Reset state, both while asserted and just after release.
    #3;
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.mem_req", 32'(mem.mem_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset.done", 32'(done), 32'd0);
    check("reset.mem_we", 32'(mem.mem_we), 32'd0);
    check("reset.mem_be", 32'(mem.mem_be), 32'd0);
    check("reset.mem_addr", 32'(mem.mem_addr), 32'd0);
    check("reset.mem_wdata", mem.mem_wdata, 32'd0);
    check("reset.load_data", load_data, 32'd0);
    check("reset.errs", 32'({addr_err, bus_err}), 32'd0);
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, 1'b0, r);
      compare($sformatf("vec%0d", i), r, vecs[i].e);
    end

    // Timeout, recovery, single-cycle done, ack exactly at the limit.
    o = '{1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0, 0};
    run_op(o, 1'b0, r);
    compare("timeout", r, '{4'hF, 30'h10, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 16});
    o = '{1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 32'h11223344, 1};
    run_op(o, 1'b0, r);
    compare("after_timeout", r, '{4'hF, 30'h11, 1'b0, 32'h0, 32'h11223344, 1'b0, 1'b0, 1});
    check("done_one_cycle", 32'(done), 32'd0);
    o = '{1'b0, 2'b10, 1'b0, 32'h48, 32'h0, 32'h55667788, 16};
    run_op(o, 1'b0, r);
    compare("ack_at_limit", r, '{4'hF, 30'h12, 1'b0, 32'h0, 32'h55667788, 1'b0, 1'b0, 16});

    // Misaligned accesses.
    o = '{1'b0, 2'b10, 1'b0, 32'h1002, 32'h0, 32'hA1B2C3D4, 1};
    run_op(o, 1'b0, r);
`ifdef MIPS_LSU_MISALIGN_TRAP_EN
    compare("mis_lw", r, '{4'h0, 30'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 0});
`else
    compare("mis_lw", r, '{4'hF, 30'h400, 1'b0, 32'h0, 32'hA1B2C3D4, 1'b0, 1'b0, 1});
`endif
    o = '{1'b1, 2'b01, 1'b0, 32'h3003, 32'h00001234, 32'h0, 1};
    run_op(o, 1'b0, r);
`ifdef MIPS_LSU_MISALIGN_TRAP_EN
    compare("mis_sh", r, '{4'h0, 30'h0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 0});
`else
    compare("mis_sh", r, '{4'hC, 30'hC00, 1'b1, 32'h12341234, 32'hA1B2C3D4, 1'b0, 1'b0, 1});
`endif
    o = '{1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h0BADF00D, 1};
    run_op(o, 1'b0, r);
    compare("err_clear", r, '{4'hF, 30'h1, 1'b0, 32'h0, 32'h0BADF00D, 1'b0, 1'b0, 1});

    // Reset in the middle of an access, then a late ack.
    op_valid = 1'b1; op_write = 1'b0; op_size = 2'b10; op_signed = 1'b0;
    op_addr = 32'h1004; op_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_mid.pre_busy", 32'(mem.mem_req), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid.req_drop", 32'(mem.mem_req), 32'd0);
    check("rst_mid.stall", 32'(stall), 32'd0);
    check("rst_mid.load_data", load_data, 32'd0);
    op_valid = 1'b0;
    mem.mem_ack = 1'b1;
    mem.mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (done || mem.mem_req || stall || load_data != 32'h0) bad++;
      @(negedge clk);
    end
    check("rst_mid.late_ack_ignored", 32'(bad), 32'd0);
    mem.mem_ack = 1'b0;
    o = '{1'b0, 2'b10, 1'b0, 32'h1008, 32'h0, 32'h13579BDF, 2};
    run_op(o, 1'b0, r);
    compare("after_rst", r, '{4'hF, 30'h402, 1'b0, 32'h0, 32'h13579BDF, 1'b0, 1'b0, 2});

    // Random ops against the model, with spurious acks outside BUSY.
    prev = 32'h13579BDF;
    for (int n = 0; n < 200; n++) begin
      int sel;
      o.wr    = 1'($urandom_range(0, 1));
      o.sz    = 2'($urandom_range(0, 3));
      o.sg    = 1'($urandom_range(0, 1));
      o.addr  = $urandom;
      o.wdata = $urandom;
      o.rdata = $urandom;
      sel = $urandom_range(0, 19);
      o.ack_at = (sel == 0) ? 0 : (sel == 1) ? TMO : $urandom_range(1, 4);
      e = model(o, prev);
      run_op(o, 1'b1, r);
      compare($sformatf("rnd%0d", n), r, e);
      prev = e.ld;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
